// File: rtl/down_counter_4bit_pkg.sv
// Shared types for the down counter: width default, terminal modes, FSM states.
// Imported by the counter top and its decrement helper.
package down_counter_4bit_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_STOP   = 2'b01,
        MODE_RELOAD = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_COUNT  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

endpackage

// File: rtl/down_counter_4bit_down_next.sv
// Ripple borrow-chain decrementer: dec = value - 1, borrow_out set when value == 0.
// Purely combinational.
module down_next
    import down_counter_4bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] dec,
    output logic             borrow_out
);

    logic [WIDTH:0] chain;

    assign chain[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign dec[i]       = value[i] ^ chain[i];
        assign chain[i + 1] = chain[i] & ~value[i];
    end

    assign borrow_out = chain[WIDTH];

endmodule

// File: rtl/down_counter_4bit.sv
// Loadable down counter with WRAP / STOP / RELOAD terminal behaviour.
// expired is the HALTED state of the control FSM, so it is a registered level.
module down_counter_4bit
    import down_counter_4bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             borrow,
    output logic             expired
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             borrow_q;
    logic             borrow_d;
    logic [WIDTH-1:0] dec;
    logic             at_zero;
    logic             is_wrap;
    logic             is_reload;
    logic             stop_hit;

    down_next #(
        .WIDTH (WIDTH)
    ) u_down_next (
        .value      (count_q),
        .dec        (dec),
        .borrow_out (at_zero)
    );

    // Mode 11 falls through to STOP behaviour.
    assign is_wrap   = (mode == MODE_WRAP);
    assign is_reload = (mode == MODE_RELOAD);
    assign stop_hit  = en && at_zero && !is_wrap && !is_reload;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load)
                    state_d = ST_COUNT;
                else if (stop_hit)
                    state_d = ST_HALTED;
                else if (en)
                    state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (!load && stop_hit)
                    state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (load || (en && (is_wrap || is_reload)))
                    state_d = ST_COUNT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        borrow_d = 1'b0;
        if (load) begin
            count_d  = load_data;
            reload_d = load_data;
        end else if (en) begin
            if (!at_zero) begin
                count_d = dec;
            end else if (is_wrap) begin
                // dec of zero is already all ones
                count_d  = dec;
                borrow_d = 1'b1;
            end else if (is_reload) begin
                count_d  = reload_q;
                borrow_d = 1'b1;
            end
        end
    end

    assign count   = count_q;
    assign zero    = at_zero;
    assign borrow  = borrow_q;
    assign expired = (state_q == ST_HALTED);

endmodule
